// File: rtl/tawas_pkg.sv
// Shared definitions for the Tawas AU issue scheduler: widths, AU opcode
// field positions and the issue-state encoding.
package tawas_pkg;

    localparam int OP_W    = 15;
    localparam int IMM_W   = 28;

    localparam int IMM_SEL = 14;
    localparam int RA_HI   = 8;
    localparam int RA_LO   = 6;
    localparam int RB_HI   = 5;
    localparam int RB_LO   = 3;
    localparam int RC_HI   = 2;
    localparam int RC_LO   = 0;

    typedef enum logic {
        ARB = 1'b0,
        OPH = 1'b1
    } state_e;

    // RA is always a source; RB is a source only for register-register ops.
    function automatic logic raw_hit(
        input logic [OP_W-1:0] op,
        input logic [2:0]      rc
    );
        return (op[RA_HI:RA_LO] == rc) ||
               (!op[IMM_SEL] && (op[RB_HI:RB_LO] == rc));
    endfunction

endpackage

// File: rtl/tawas_rr_arb2.sv
// Two-input round-robin arbiter with a candidate mask and a lock that
// forces the grant while an immediate/op pair is in progress.
module tawas_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       lock_i,
    input  logic       lock_idx_i,
    input  logic       upd_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    logic       ptr_q;
    logic       ptr_d;
    logic [1:0] cand;

    assign cand = req_i & ~mask_i;

    // ptr_q holds the last granted requester; the other one wins a tie.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = 1'b0;
        priority case (1'b1)
            lock_i: begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = lock_idx_i;
            end
            &cand: begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = ~ptr_q;
            end
            cand[0]: begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = 1'b0;
            end
            cand[1]: begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign ptr_d = upd_i ? gnt_idx_o : ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tawas_au_sched.sv
// Shares the Tawas AU between two thread requesters (slice 0 / slice 1).
// Optional RAW interlock: define TAWAS_AU_SCHED_HAZARD_EN.
module tawas_au_sched
    import tawas_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       REQ_VLD,
    output logic [1:0]       REQ_RDY,
    input  logic [OP_W-1:0]  REQ_OP0,
    input  logic [OP_W-1:0]  REQ_OP1,
    input  logic [1:0]       REQ_IMM_VLD,
    input  logic [IMM_W-1:0] REQ_IMM0,
    input  logic [IMM_W-1:0] REQ_IMM1,
    output logic             SLICE,
    output logic             AU_OP_VLD,
    output logic [OP_W-1:0]  AU_OP,
    output logic             AU_OP_IMM_VLD,
    output logic [IMM_W-1:0] AU_OP_IMM,
    input  logic             AU_RC_VLD,
    input  logic [2:0]       AU_RC_SEL,
    output logic [1:0]       RSP_VLD,
    output logic             BUSY
);

    state_e           state_q;
    state_e           state_d;
    logic             lock_q;
    logic             lock_d;
    logic             slice_q;
    logic             slice_d;
    logic             op_vld_q;
    logic             op_vld_d;
    logic [OP_W-1:0]  op_q;
    logic [OP_W-1:0]  op_d;
    logic             imm_vld_q;
    logic             imm_vld_d;
    logic [IMM_W-1:0] imm_q;
    logic [IMM_W-1:0] imm_d;

    logic             tag_q;
    logic             infl_q;
    logic [2:0]       rc_q;

    logic [1:0]       rdy;
    logic [1:0]       blk;
    logic             gnt_vld;
    logic             gnt_idx;
    logic             upd;

    logic [OP_W-1:0]  sel_op;
    logic [IMM_W-1:0] sel_imm;
    logic             sel_immv;

    assign sel_op   = gnt_idx ? REQ_OP1  : REQ_OP0;
    assign sel_imm  = gnt_idx ? REQ_IMM1 : REQ_IMM0;
    assign sel_immv = REQ_IMM_VLD[gnt_idx];

`ifdef TAWAS_AU_SCHED_HAZARD_EN
    // The op on the AU this cycle writes back next cycle; block readers.
    always_comb begin
        blk    = 2'b00;
        blk[0] = op_vld_q && !slice_q &&
                 raw_hit(REQ_OP0, op_q[RC_HI:RC_LO]);
        blk[1] = op_vld_q && slice_q &&
                 raw_hit(REQ_OP1, op_q[RC_HI:RC_LO]);
    end
`else
    assign blk = 2'b00;
`endif

    tawas_rr_arb2 u_arb (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .req_i      (REQ_VLD),
        .mask_i     (blk),
        .lock_i     (state_q == OPH),
        .lock_idx_i (lock_q),
        .upd_i      (upd),
        .gnt_vld_o  (gnt_vld),
        .gnt_idx_o  (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        slice_d   = slice_q;
        op_vld_d  = 1'b0;
        op_d      = op_q;
        imm_vld_d = 1'b0;
        imm_d     = imm_q;
        rdy       = 2'b00;
        upd       = 1'b0;
        unique case (state_q)
            ARB: begin
                if (gnt_vld) begin
                    slice_d = gnt_idx;
                    if (sel_immv) begin
                        imm_vld_d = 1'b1;
                        imm_d     = sel_imm;
                        lock_d    = gnt_idx;
                        state_d   = OPH;
                    end else begin
                        rdy[gnt_idx] = 1'b1;
                        op_vld_d     = 1'b1;
                        op_d         = sel_op;
                        upd          = 1'b1;
                    end
                end
            end
            OPH: begin
                rdy[gnt_idx] = 1'b1;
                op_vld_d     = 1'b1;
                op_d         = sel_op;
                slice_d      = gnt_idx;
                upd          = 1'b1;
                state_d      = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ARB;
            lock_q    <= 1'b0;
            slice_q   <= 1'b0;
            op_vld_q  <= 1'b0;
            op_q      <= '0;
            imm_vld_q <= 1'b0;
            imm_q     <= '0;
            tag_q     <= 1'b0;
            infl_q    <= 1'b0;
            rc_q      <= 3'd0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            slice_q   <= slice_d;
            op_vld_q  <= op_vld_d;
            op_q      <= op_d;
            imm_vld_q <= imm_vld_d;
            imm_q     <= imm_d;
            infl_q    <= op_vld_q;
            if (op_vld_q) begin
                tag_q <= slice_q;
                rc_q  <= op_q[RC_HI:RC_LO];
            end
        end
    end

    assign REQ_RDY       = rdy & {2{RST}};
    assign SLICE         = slice_q;
    assign AU_OP_VLD     = op_vld_q;
    assign AU_OP         = op_q;
    assign AU_OP_IMM_VLD = imm_vld_q;
    assign AU_OP_IMM     = imm_q;
    assign RSP_VLD       = {AU_RC_VLD & infl_q & tag_q,
                            AU_RC_VLD & infl_q & ~tag_q};
    assign BUSY          = (state_q != ARB) | op_vld_q | imm_vld_q;

`ifndef SYNTHESIS
    // A result must follow an AU op by exactly one cycle.
    ap_rc_orphan: assert property (
        @(posedge CLK) disable iff (!RST) AU_RC_VLD |-> infl_q);
    ap_rc_sel: assert property (
        @(posedge CLK) disable iff (!RST)
        (AU_RC_VLD && infl_q) |-> (AU_RC_SEL == rc_q));
`endif

endmodule

// File: doc/tawas_au_sched.md
Name: tawas_au_sched

Overview:
- Issue scheduler that shares the single Tawas arithmetic unit between two thread requesters; requester 0 owns SLICE 0 and requester 1 owns SLICE 1.
- Round-robin arbitration between the two requesters.
- Sequences immediate-prefixed ops as an IMM cycle followed by an OP cycle on the same slice.
- Routes AU result-valid back to the owning requester; optional RAW interlock.
- Sits between the thread decode front-ends and the AU input ports.

Parameters:
- OP_W, 15, AU opcode width; bit 14 = immediate-select.
- IMM_W, 28, width of the immediate prefix (AU imm bits [31:4]).

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-low (asserted at 0)
- REQ_VLD  in  2  per-requester op valid
- REQ_RDY  out  2  per-requester op accepted (combinational, one-hot or zero)
- REQ_OP0, REQ_OP1  in  OP_W  requester opcode
- REQ_IMM_VLD  in  2  request carries an immediate prefix
- REQ_IMM0, REQ_IMM1  in  IMM_W  immediate prefix
- SLICE  out  1  slice of current AU drive
- AU_OP_VLD  out  1  to AU
- AU_OP  out  OP_W  to AU
- AU_OP_IMM_VLD  out  1  to AU
- AU_OP_IMM  out  IMM_W  to AU
- AU_RC_VLD  in  1  AU result valid
- AU_RC_SEL  in  3  AU result register (hazard tracking only)
- RSP_VLD  out  2  per-requester result valid
- BUSY  out  1  state != ARB or any AU output valid

Behaviour:
- Reset (RST=0): SLICE=0, AU_OP_VLD=0, AU_OP=0, AU_OP_IMM_VLD=0, AU_OP_IMM=0, RSP_VLD=0, REQ_RDY=0, BUSY=0, state=ARB, last-grant pointer=1 (requester 0 wins first).
- Reset mid-operation discards any pending IMM/OP pair with no response. The requester must re-present it.
- All AU-side outputs are registered. A decision in cycle N drives the AU in cycle N+1.
- Requesters hold REQ_VLD/OP/IMM stable until REQ_RDY. Dropping VLD before RDY is illegal.
- State ARB:
  - Candidates are requesters with REQ_VLD=1 that are not hazard-blocked.
  - If both are candidates, grant the one that is not the last-grant pointer. Otherwise grant the single candidate. If none, drive AU valids low and stay in ARB.
  - Plain op (REQ_IMM_VLD=0): REQ_RDY[g]=1 in N. Next cycle AU_OP_VLD=1, AU_OP=op, SLICE=g. Pointer<=g. Stay in ARB.
  - Immediate op: no RDY in N. Next cycle AU_OP_IMM_VLD=1, AU_OP_IMM=imm, AU_OP_VLD=0, SLICE=g. Lock g and go to OPH.
- State OPH:
  - Unconditionally REQ_RDY[g]=1 and capture the op; the other requester is ignored.
  - Next cycle AU_OP_VLD=1, SLICE=g, AU_OP_IMM_VLD=0. Pointer<=g. Return to ARB.
  - No other slice use may intervene between an IMM cycle and its OP cycle.
- Throughput: 1 plain op/cycle; an immediate op costs 2 issue cycles.
- Response tracking:
  - The tag FIFO is one entry deep (tag register = SLICE of last AU_OP_VLD).
  - RSP_VLD[tag] = AU_RC_VLD, registered-aligned. An op driven to the AU in cycle M gets RSP_VLD at M+1. An op accepted in N therefore responds at N+2 (plain) or N+3 (immediate).
- Back-to-back ops with the same slice and ops that alternate slices are both legal; the tag register updates every AU_OP_VLD cycle.
- AU_RC_VLD without a matching earlier AU_OP_VLD is a protocol error; it is asserted on in simulation.

Optional Feature:
- Macro: TAWAS_AU_SCHED_HAZARD_EN.
- When defined: a requester is hazard-blocked in ARB when both hold:
  - AU_OP_VLD=1 with SLICE equal to its slice, i.e. the in-flight writeback has not landed.
  - Its REQ_OP[8:6], or REQ_OP[5:3] when bit 14=0, equals the registered in-flight AU_OP[2:0].
- A blocked requester loses that cycle. If it is the sole requester, the AU idles one bubble.
- OPH capture is never blocked; the prefix cycle already supplies the gap.
- When undefined: no blocking. Software or the register file bypass handles RAW hazards.

Decomposition:
- Shared package tawas_pkg: OP_W, IMM_W, AU_OP bit positions (IMM_SEL=14, RA=8:6, RB=5:3, RC=2:0), and the state enum {ARB, OPH}.
- One sub-module tawas_rr_arb2: two-input round-robin grant with pointer update, lock input and candidate mask.
- Everything else lives in tawas_au_sched.

Test Plan:
- Reset then REQ_VLD=2'b01, op 0x1000, no imm -> REQ_RDY=01 cycle 0; AU_OP_VLD=1, AU_OP=0x1000, SLICE=0 cycle 1; with AU_RC_VLD fed at cycle 2 -> RSP_VLD=01 cycle 2.
- Both requesters valid, plain ops held 6 cycles -> grants alternate 0,1,0,1,0,1; SLICE alternates; RSP_VLD one-hot, following each slice one cycle after its AU_OP_VLD.
- Requester 1 immediate op (imm 0xABCDEF0, op 0x4A03) while requester 0 valid -> cycle 1 AU_OP_IMM_VLD=1, AU_OP_IMM=0xABCDEF0, SLICE=1; cycle 2 AU_OP_VLD=1, SLICE=1, RDY[1] in cycle 1; requester 0 not granted until the cycle after OPH.
- RST driven low during OPH -> all outputs 0 immediately; after release, the same requester re-presents and the full IMM+OP sequence replays.
- HAZARD_EN: requester 0 sole, op0 RC=3 then op1 RA=3 -> one idle bubble between AU_OP_VLD pulses. Macro undefined -> back-to-back issue.
- Pointer fairness: requester 0 alone for 3 ops, then both valid -> requester 1 granted first.
